complex_accumulator: RTL and testbench

- Downstream stage of the complex multiplier.
- Consumes the signed product stream (z_real, z_imag) plus a one-cycle valid strobe.
- Sums FRAME_LEN consecutive valid products into a complex dot-product result and emits it with a one-cycle acc_valid pulse.
- Supports frame abort via clear and optional saturating arithmetic.

---
 rtl/complex_accumulator.sv | 181 ++++++++++++++++++
 tb/tb_complex_accumulator.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/complex_accumulator.sv
// complex_accumulator: sums FRAME_LEN consecutive valid complex products into
// one dot-product result, presented with a single-cycle acc_valid pulse.
// clear aborts the partial frame; rst (synchronous, active-high) resets all.
// Optional build macro COMPLEX_ACC_SAT_EN: saturating adds plus an overflow
// report. Without it the adds wrap and overflow is tied low.
// ACC_W must be >= IN_W; FRAME_LEN must lie in 1..255.
module complex_accumulator #(
    parameter int IN_W      = 16,
    parameter int ACC_W     = 24,
    parameter int FRAME_LEN = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [IN_W-1:0]  z_real,
    input  logic signed [IN_W-1:0]  z_imag,
    input  logic                    z_valid,
    input  logic                    clear,
    output logic signed [ACC_W-1:0] acc_real,
    output logic signed [ACC_W-1:0] acc_imag,
    output logic                    acc_valid,
    output logic                    busy,
    output logic                    overflow
);

    // Index of the sample that closes a frame (0 when FRAME_LEN is 1).
    localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

`ifdef COMPLEX_ACC_SAT_EN
    // Signed add clamped to the ACC_W range; MSB of the result flags a clamp.
    function automatic logic [ACC_W:0] sat_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b
    );
        logic signed [ACC_W-1:0] raw;
        logic signed [ACC_W-1:0] lim;
        logic                    ovf;
        raw = a + b;
        ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);
        lim = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        return {ovf, (ovf ? lim : raw)};
    endfunction
`else
    // Plain two's-complement add, wrapping modulo 2^ACC_W.
    function automatic logic signed [ACC_W-1:0] wrap_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b
    );
        return a + b;
    endfunction
`endif

    state_t                  state_q, state_d;
    logic [7:0]              count_q, count_d;
    logic signed [ACC_W-1:0] sum_real_q, sum_real_d;
    logic signed [ACC_W-1:0] sum_imag_q, sum_imag_d;
    logic signed [ACC_W-1:0] acc_real_q, acc_real_d;
    logic signed [ACC_W-1:0] acc_imag_q, acc_imag_d;
    logic                    acc_valid_q, acc_valid_d;

    logic signed [ACC_W-1:0] ext_real_s;
    logic signed [ACC_W-1:0] ext_imag_s;
    logic signed [ACC_W-1:0] nxt_real_s;
    logic signed [ACC_W-1:0] nxt_imag_s;

`ifdef COMPLEX_ACC_SAT_EN
    logic                    flag_q, flag_d;
    logic                    ovf_q, ovf_d;
    logic [ACC_W:0]          add_real_s;
    logic [ACC_W:0]          add_imag_s;
    logic                    samp_ovf_s;
`endif

    // Sign-extend the incoming components to accumulator width.
    assign ext_real_s = ACC_W'(z_real);
    assign ext_imag_s = ACC_W'(z_imag);

`ifdef COMPLEX_ACC_SAT_EN
    assign add_real_s = sat_add(sum_real_q, ext_real_s);
    assign add_imag_s = sat_add(sum_imag_q, ext_imag_s);
    assign nxt_real_s = add_real_s[ACC_W-1:0];
    assign nxt_imag_s = add_imag_s[ACC_W-1:0];
    assign samp_ovf_s = add_real_s[ACC_W] | add_imag_s[ACC_W];
`else
    assign nxt_real_s = wrap_add(sum_real_q, ext_real_s);
    assign nxt_imag_s = wrap_add(sum_imag_q, ext_imag_s);
`endif

    // Next-state logic: clear beats z_valid; the last sample of a frame
    // publishes the sums and restarts the accumulator in the same cycle.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        sum_real_d  = sum_real_q;
        sum_imag_d  = sum_imag_q;
        acc_real_d  = acc_real_q;
        acc_imag_d  = acc_imag_q;
        acc_valid_d = 1'b0;
`ifdef COMPLEX_ACC_SAT_EN
        flag_d      = flag_q;
        ovf_d       = ovf_q;
`endif
        if (clear) begin
            state_d    = ST_IDLE;
            count_d    = 8'd0;
            sum_real_d = '0;
            sum_imag_d = '0;
`ifdef COMPLEX_ACC_SAT_EN
            flag_d     = 1'b0;
`endif
        end else if (z_valid) begin
            if (count_q == LAST_IDX) begin
                acc_real_d  = nxt_real_s;
                acc_imag_d  = nxt_imag_s;
                acc_valid_d = 1'b1;
                state_d     = ST_IDLE;
                count_d     = 8'd0;
                sum_real_d  = '0;
                sum_imag_d  = '0;
`ifdef COMPLEX_ACC_SAT_EN
                ovf_d       = flag_q | samp_ovf_s;
                flag_d      = 1'b0;
`endif
            end else begin
                state_d    = ST_ACCUM;
                count_d    = count_q + 8'd1;
                sum_real_d = nxt_real_s;
                sum_imag_d = nxt_imag_s;
`ifdef COMPLEX_ACC_SAT_EN
                flag_d     = flag_q | samp_ovf_s;
`endif
            end
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            count_q     <= 8'd0;
            sum_real_q  <= '0;
            sum_imag_q  <= '0;
            acc_real_q  <= '0;
            acc_imag_q  <= '0;
            acc_valid_q <= 1'b0;
`ifdef COMPLEX_ACC_SAT_EN
            flag_q      <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            sum_real_q  <= sum_real_d;
            sum_imag_q  <= sum_imag_d;
            acc_real_q  <= acc_real_d;
            acc_imag_q  <= acc_imag_d;
            acc_valid_q <= acc_valid_d;
`ifdef COMPLEX_ACC_SAT_EN
            flag_q      <= flag_d;
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign acc_real  = acc_real_q;
    assign acc_imag  = acc_imag_q;
    assign acc_valid = acc_valid_q;
    assign busy      = (state_q == ST_ACCUM);
`ifdef COMPLEX_ACC_SAT_EN
    assign overflow  = ovf_q;
`else
    assign overflow  = 1'b0;
`endif

endmodule

// File: tb/tb_complex_accumulator.sv
// Directed bench for complex_accumulator: a default instance (FRAME_LEN=4,
// ACC_W=24), a FRAME_LEN=1 instance and an ACC_W=16 instance share stimulus.
module tb_complex_accumulator;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] zr, zi;
    logic               zv, clr;

    logic signed [23:0] a_re, a_im;
    logic               a_v, a_busy, a_ovf;
    logic signed [23:0] b_re, b_im;
    logic               b_v, b_busy, b_ovf;
    logic signed [15:0] c_re, c_im;
    logic               c_v, c_busy, c_ovf;

    int vectors = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    complex_accumulator #(.IN_W(16), .ACC_W(24), .FRAME_LEN(4)) dut (
        .clk(clk), .rst(rst), .z_real(zr), .z_imag(zi), .z_valid(zv), .clear(clr),
        .acc_real(a_re), .acc_imag(a_im), .acc_valid(a_v), .busy(a_busy), .overflow(a_ovf));

    complex_accumulator #(.IN_W(16), .ACC_W(24), .FRAME_LEN(1)) dut_f1 (
        .clk(clk), .rst(rst), .z_real(zr), .z_imag(zi), .z_valid(zv), .clear(clr),
        .acc_real(b_re), .acc_imag(b_im), .acc_valid(b_v), .busy(b_busy), .overflow(b_ovf));

    complex_accumulator #(.IN_W(16), .ACC_W(16), .FRAME_LEN(4)) dut_w16 (
        .clk(clk), .rst(rst), .z_real(zr), .z_imag(zi), .z_valid(zv), .clear(clr),
        .acc_real(c_re), .acc_imag(c_im), .acc_valid(c_v), .busy(c_busy), .overflow(c_ovf));

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic signed [15:0] r, input logic signed [15:0] i);
        zr = r;
        zi = i;
        zv = 1'b1;
        tick();
        zv = 1'b0;
    endtask

    task automatic idle();
        zv = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; zv = 1'b0; clr = 1'b0; zr = '0; zi = '0;
        tick();
        tick();
        chk("rst_acc_real",  a_re,   0);
        chk("rst_acc_imag",  a_im,   0);
        chk("rst_acc_valid", a_v,    0);
        chk("rst_busy",      a_busy, 0);
        chk("rst_overflow",  a_ovf,  0);
        rst = 1'b0;

        // Gapped frame, two idle cycles between samples
        sample(-16'sd5, 16'sd10);
        chk("gap_busy_s1",   a_busy, 1);
        chk("gap_valid_s1",  a_v,    0);
        chk("f1_valid",      b_v,    1);
        chk("f1_real",       b_re,   -5);
        chk("f1_imag",       b_im,   10);
        idle();
        chk("gap_busy_idle", a_busy, 1);
        chk("f1_valid_off",  b_v,    0);
        chk("f1_hold_real",  b_re,   -5);
        idle();
        sample(-16'sd20, 16'sd40);
        idle();
        idle();
        sample(-16'sd16, 16'sd22);
        chk("gap_valid_s3",  a_v,    0);
        chk("gap_busy_s3",   a_busy, 1);
        idle();
        idle();
        sample(-16'sd3, 16'sd4);
        chk("gap_valid",     a_v,    1);
        chk("gap_real",      a_re,   -44);
        chk("gap_imag",      a_im,   76);
        chk("gap_ovf",       a_ovf,  0);
        chk("gap_busy_end",  a_busy, 0);
        idle();
        chk("gap_pulse_end", a_v,    0);
        chk("gap_hold_real", a_re,   -44);

        // Back-to-back frames of (1,-1)
        for (int n = 1; n <= 8; n++) begin
            sample(16'sd1, -16'sd1);
            if (n == 4 || n == 8) begin
                chk("b2b_valid", a_v,  1);
                chk("b2b_real",  a_re, 4);
                chk("b2b_imag",  a_im, -4);
            end else begin
                chk("b2b_novalid", a_v, 0);
            end
            if (n == 5) chk("b2b_busy_next", a_busy, 1);
        end
        idle();
        chk("b2b_pulse_end", a_v, 0);

        // Clear with a coincident valid sample
        sample(16'sd100, 16'sd100);
        sample(16'sd100, 16'sd100);
        clr = 1'b1; zr = 16'sd50; zi = 16'sd50; zv = 1'b1;
        tick();
        clr = 1'b0; zv = 1'b0;
        chk("clr_busy",      a_busy, 0);
        chk("clr_valid",     a_v,    0);
        chk("clr_hold_real", a_re,   4);
        for (int n = 1; n <= 4; n++) begin
            sample(-16'sd9, 16'sd38);
            if (n < 4) chk("clr_novalid", a_v, 0);
        end
        chk("clr_valid_end", a_v,  1);
        chk("clr_real",      a_re, -36);
        chk("clr_imag",      a_im, 152);

        // Reset mid-frame
        sample(16'sd7, 16'sd7);
        sample(16'sd7, 16'sd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_real",  a_re,   0);
        chk("mrst_imag",  a_im,   0);
        chk("mrst_valid", a_v,    0);
        chk("mrst_busy",  a_busy, 0);
        chk("mrst_ovf",   a_ovf,  0);
        for (int n = 1; n <= 4; n++) sample(16'sd1, 16'sd2);
        chk("mrst_res_valid", a_v,  1);
        chk("mrst_res_real",  a_re, 4);
        chk("mrst_res_imag",  a_im, 8);

        // Overflow on the 16-bit accumulator; the 24-bit one holds it exactly
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int n = 1; n <= 4; n++) sample(16'sd32767, 16'sd0);
        chk("ovf16_valid", c_v,  1);
        chk("ovf16_imag",  c_im, 0);
`ifdef COMPLEX_ACC_SAT_EN
        chk("ovf16_real",  c_re,  32767);
        chk("ovf16_flag",  c_ovf, 1);
`else
        chk("ovf16_real",  c_re,  -4);
        chk("ovf16_flag",  c_ovf, 0);
`endif
        chk("ovf24_real",  a_re,  131068);
        chk("ovf24_flag",  a_ovf, 0);
        sample(16'sd1, 16'sd1);
        chk("ovf16_hold_flag", c_ovf, `ifdef COMPLEX_ACC_SAT_EN 1 `else 0 `endif);
        chk("ovf16_busy",      c_busy, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
